// File: rtl/cpu_clock_gen.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_clock_gen
//  Description : Bus-clock generator for the 8-bit CPU. Produces a free-run
//                bus clock with selectable speed, a debounced single-step
//                mode and a latched halt, plus edge pulses and a wrapping
//                count of bus-clock rising edges.
//  Revision    : 1.0  initial release
// ============================================================================
module cpu_clock_gen #(
  parameter int MIN_LOG2    = 18,
  parameter int SPEED_BITS  = 3,
  parameter int DB_WIDTH    = 20,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   run_mode,
  input  logic [SPEED_BITS-1:0]  speed,
  input  logic                   step_btn,
  input  logic                   hlt,
  output logic                   bus_clk,
  output logic                   control_clk,
  output logic                   bus_rise,
  output logic                   bus_fall,
  output logic                   halted,
  output logic [COUNT_WIDTH-1:0] cycle_count
);

  // Prescaler must hold the largest half-period: 2^(MIN_LOG2 + 2^SPEED_BITS - 1).
  localparam int                PW         = MIN_LOG2 + (1 << SPEED_BITS);
  localparam logic [PW-1:0]     ONE        = PW'(1);
  localparam logic [PW-1:0]     STEP_LIMIT = PW'((64'd1 << MIN_LOG2) - 64'd1);
  localparam logic [DB_WIDTH-1:0] DB_MAX   = '1;
  localparam logic [COUNT_WIDTH-1:0] CNT_ONE = COUNT_WIDTH'(1);

  typedef enum logic [1:0] {
    S_LOW       = 2'd0,
    S_HIGH_RUN  = 2'd1,
    S_HIGH_STEP = 2'd2,
    S_HALTED    = 2'd3
  } state_e;

  state_e                 state_q;
  logic [PW-1:0]          presc_q;
  logic                   bus_q;
  logic                   ctrl_q;
  logic                   rise_q;
  logic                   fall_q;
  logic                   halted_q;
  logic [COUNT_WIDTH-1:0] count_q;

  logic                   sync1_q;
  logic                   sync2_q;
  logic                   db_level_q;
  logic [DB_WIDTH-1:0]    db_cnt_q;

  logic [PW-1:0]          presc_limit;
  logic [PW-1:0]          presc_inc;
  logic                   db_rise;

  // Speed is applied combinationally so a change takes effect immediately;
  // the >= compare handles a count already beyond a newly lowered limit.
  assign presc_limit = (ONE << (MIN_LOG2 + int'(speed))) - ONE;
  assign presc_inc   = presc_q + ONE;

  // Debounced level is about to flip 0->1 on this edge.
  assign db_rise = sync2_q & ~db_level_q & (db_cnt_q == DB_MAX);

  // Synchronise the raw button and debounce it: flip only after a full run
  // of disagreeing cycles, any agreement restarts the run.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      db_level_q <= 1'b0;
      db_cnt_q   <= '0;
    end else begin
      sync1_q <= step_btn;
      sync2_q <= sync1_q;
      if (sync2_q != db_level_q) begin
        if (db_cnt_q == DB_MAX) begin
          db_level_q <= sync2_q;
          db_cnt_q   <= '0;
        end else begin
          db_cnt_q <= db_cnt_q + {{(DB_WIDTH-1){1'b0}}, 1'b1};
        end
      end else begin
        db_cnt_q <= '0;
      end
    end
  end

  // Phase FSM with registered bus clock, edge pulses, halt flag and counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_LOW;
      presc_q  <= '0;
      bus_q    <= 1'b0;
      ctrl_q   <= 1'b1;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
      halted_q <= 1'b0;
      count_q  <= '0;
    end else begin
      rise_q <= 1'b0;
      fall_q <= 1'b0;
      case (state_q)
        S_LOW: begin
          if (hlt) begin
            state_q  <= S_HALTED;
            halted_q <= 1'b1;
            presc_q  <= '0;
          end else if (run_mode) begin
            if (presc_q >= presc_limit) begin
              state_q <= S_HIGH_RUN;
              presc_q <= '0;
              bus_q   <= 1'b1;
              ctrl_q  <= 1'b0;
              rise_q  <= 1'b1;
              count_q <= count_q + CNT_ONE;
            end else begin
              presc_q <= presc_inc;
            end
          end else if (db_rise) begin
            state_q <= S_HIGH_STEP;
            presc_q <= '0;
            bus_q   <= 1'b1;
            ctrl_q  <= 1'b0;
            rise_q  <= 1'b1;
            count_q <= count_q + CNT_ONE;
          end
        end
        S_HIGH_RUN, S_HIGH_STEP: begin
          // A high phase keeps the length rule of the state it started in.
          if (presc_q >= ((state_q == S_HIGH_RUN) ? presc_limit : STEP_LIMIT)) begin
            state_q <= S_LOW;
            presc_q <= '0;
            bus_q   <= 1'b0;
            ctrl_q  <= 1'b1;
            fall_q  <= 1'b1;
          end else begin
            presc_q <= presc_inc;
          end
        end
        default: begin
          // Halted: only reset leaves this state.
          halted_q <= 1'b1;
        end
      endcase
    end
  end

  assign bus_clk     = bus_q;
  assign control_clk = ctrl_q;
  assign bus_rise    = rise_q;
  assign bus_fall    = fall_q;
  assign halted      = halted_q;
  assign cycle_count = count_q;

endmodule
`default_nettype wire

// File: tb/tb_cpu_clock_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cpu_clock_gen
//  Description : Self-checking bench for cpu_clock_gen. Each scenario builds
//                the expected per-cycle output vector
//                {bus_clk, control_clk, bus_rise, bus_fall, halted, count}
//                from a list of bus-clock toggle edges and compares it with
//                the DUT cycle by cycle.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_cpu_clock_gen;

  logic       clk = 1'b0;
  logic       rst;
  logic       run_mode;
  logic [2:0] speed;
  logic       step_btn;
  logic       hlt;
  logic       bus_clk;
  logic       control_clk;
  logic       bus_rise;
  logic       bus_fall;
  logic       halted;
  logic [3:0] cycle_count;

  int errors = 0;
  int checks = 0;

  logic [8:0] exp_q[$];
  int         tog_q[$];
  logic [8:0] got;
  logic [8:0] want;

  localparam logic [8:0] RESET_VEC = 9'b0_1_0_0_0_0000;

  cpu_clock_gen #(
    .MIN_LOG2   (2),
    .SPEED_BITS (3),
    .DB_WIDTH   (2),
    .COUNT_WIDTH(4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .run_mode   (run_mode),
    .speed      (speed),
    .step_btn   (step_btn),
    .hlt        (hlt),
    .bus_clk    (bus_clk),
    .control_clk(control_clk),
    .bus_rise   (bus_rise),
    .bus_fall   (bus_fall),
    .halted     (halted),
    .cycle_count(cycle_count)
  );

  always #5 clk = ~clk;

  function automatic logic [8:0] obs();
    return {bus_clk, control_clk, bus_rise, bus_fall, halted, cycle_count};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected outputs for edges 1..n after release: bus_clk toggles at each
  // edge listed in tog_q, rises count up (4-bit wrap), halted from halt_at.
  task automatic build(input int n, input int halt_at, input logic [3:0] cnt0);
    logic b, r, f, h;
    logic [3:0] c;
    b = 1'b0;
    c = cnt0;
    for (int e = 1; e <= n; e++) begin
      r = 1'b0;
      f = 1'b0;
      if (tog_q.size() > 0 && tog_q[0] == e) begin
        void'(tog_q.pop_front());
        b = ~b;
        if (b) begin
          r = 1'b1;
          c = c + 4'd1;
        end else begin
          f = 1'b1;
        end
      end
      h = (halt_at > 0) && (e >= halt_at);
      exp_q.push_back({b, ~b, r, f, h, c});
    end
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; run_mode = 1'b1; speed = 3'd0; step_btn = 1'b1; hlt = 1'b0;
    tick();
    tick();
    checks++;
    if (obs() !== RESET_VEC) begin
      errors++;
      $display("FAIL reset_state got=%b want=%b", obs(), RESET_VEC);
    end
    step_btn = 1'b0;
    tick();
    checks++;
    if (obs() !== RESET_VEC) begin
      errors++;
      $display("FAIL reset_hold got=%b want=%b", obs(), RESET_VEC);
    end
    rst = 1'b0;
  endtask

  task automatic test_free_run();
    run_mode = 1'b1; speed = 3'd0;
    apply_reset();
    tog_q = '{4, 8, 12, 16, 20, 24};
    build(26, 0, 4'd0);
    for (int e = 1; e <= 26; e++) begin
      tick();
      got = obs(); want = exp_q.pop_front(); checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL free_run e=%0d got=%b want=%b", e, got, want);
      end
    end
  endtask

  task automatic test_speed_change();
    run_mode = 1'b1; speed = 3'd0;
    apply_reset();
    tog_q = '{4, 8, 12, 16, 32, 48, 64, 74, 78, 82};
    build(84, 0, 4'd0);
    for (int e = 1; e <= 84; e++) begin
      tick();
      got = obs(); want = exp_q.pop_front(); checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL speed_change e=%0d got=%b want=%b", e, got, want);
      end
      if (e == 17) speed = 3'd2;   // prescaler = 1 in LOW
      if (e == 73) speed = 3'd0;   // prescaler = 9 in HIGH_RUN
    end
  endtask

  task automatic test_step_mode();
    run_mode = 1'b0; speed = 3'd0; step_btn = 1'b0;
    apply_reset();
    // press -> one 4-cycle pulse; glitch -> nothing; debounced edge landing
    // inside a free-run high phase -> discarded after switching back to step
    tog_q = '{8, 12, 34, 38};
    build(50, 0, 4'd0);
    for (int e = 1; e <= 50; e++) begin
      tick();
      got = obs(); want = exp_q.pop_front(); checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL step_mode e=%0d got=%b want=%b", e, got, want);
      end
      if (e == 2)  step_btn = 1'b1;
      if (e == 12) step_btn = 1'b0;
      if (e == 22) step_btn = 1'b1;
      if (e == 25) step_btn = 1'b0;
      if (e == 30) begin run_mode = 1'b1; step_btn = 1'b1; end
      if (e == 35) run_mode = 1'b0;
    end
    step_btn = 1'b0;
  endtask

  task automatic test_halt();
    run_mode = 1'b1; speed = 3'd0; hlt = 1'b0;
    apply_reset();
    tog_q = '{4, 8};
    build(30, 9, 4'd0);
    for (int e = 1; e <= 30; e++) begin
      tick();
      got = obs(); want = exp_q.pop_front(); checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL halt e=%0d got=%b want=%b", e, got, want);
      end
      if (e == 5)  hlt = 1'b1;
      if (e == 15) hlt = 1'b0;
    end
    rst = 1'b1;
    tick();
    checks++;
    if (obs() !== RESET_VEC) begin
      errors++;
      $display("FAIL halt_clear got=%b want=%b", obs(), RESET_VEC);
    end
    rst = 1'b0;
  endtask

  task automatic test_reset_mid_high();
    run_mode = 1'b1; speed = 3'd0;
    apply_reset();
    tog_q = '{4};
    build(5, 0, 4'd0);
    for (int e = 1; e <= 5; e++) begin
      tick();
      got = obs(); want = exp_q.pop_front(); checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL mid_reset_pre e=%0d got=%b want=%b", e, got, want);
      end
    end
    rst = 1'b1;
    tick();
    checks++;
    if (obs() !== RESET_VEC) begin
      errors++;
      $display("FAIL mid_reset got=%b want=%b", obs(), RESET_VEC);
    end
    rst = 1'b0;
    tog_q = '{4, 8};
    build(10, 0, 4'd0);
    for (int e = 1; e <= 10; e++) begin
      tick();
      got = obs(); want = exp_q.pop_front(); checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL mid_reset_restart e=%0d got=%b want=%b", e, got, want);
      end
    end
  endtask

  task automatic test_wrap();
    run_mode = 1'b1; speed = 3'd0;
    apply_reset();
    tog_q.delete();
    for (int k = 1; k <= 31; k++) tog_q.push_back(4 * k);
    build(126, 0, 4'd0);
    for (int e = 1; e <= 126; e++) begin
      tick();
      got = obs(); want = exp_q.pop_front(); checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL wrap e=%0d got=%b want=%b", e, got, want);
      end
    end
  endtask

  initial begin
    rst = 1'b1; run_mode = 1'b1; speed = 3'd0; step_btn = 1'b0; hlt = 1'b0;
    test_reset();
    test_free_run();
    test_speed_change();
    test_step_mode();
    test_halt();
    test_reset_mid_high();
    test_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
